// File: rtl/time_core_alarm.sv
// Time-of-day counter (hh:mm:ss) with a one-second prescaler, set mode,
// BCD/12-hour display decode and a single daily alarm with auto-stop.
module time_core_alarm #(
   parameter int unsigned TICK_DIV  = 100000000,
   parameter int unsigned MODE_12H  = 0,
   parameter int unsigned RING_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       adjust,
   input  logic       ENTH,
   input  logic       ENTM,
   input  logic       updown,
   input  logic [4:0] alarm_h,
   input  logic [5:0] alarm_m,
   input  logic       alarm_load,
   input  logic       alarm_en,
   input  logic       alarm_stop,
   output logic [1:0] H1,
   output logic [3:0] H2,
   output logic [2:0] M1,
   output logic [3:0] M2,
   output logic [2:0] S1,
   output logic [3:0] S2,
   output logic       pm,
   output logic       tick,
   output logic       alarm_ring
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]    RMAX = 8'(RING_SECS - 1);

   typedef enum logic {RING_IDLE, RING_ON} ring_e;

   logic [PW-1:0] pre_q, pre_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hr_q, hr_d;
   logic [4:0]    al_h_q;
   logic [5:0]    al_m_q;
   logic [7:0]    rcnt_q;
   ring_e         ring_q;
   logic          tick_int;
   logic          match;
   logic          ring_clr;
   logic [4:0]    disp_h;

   // Gated by rst so a TICK_DIV of 1 does not strobe while held in reset.
   always_comb tick_int = rst && !adjust && (pre_q == PMAX);

   always_comb begin
      pre_d = pre_q;
      sec_d = sec_q;
      min_d = min_q;
      hr_d  = hr_q;
      if (adjust) begin
         pre_d = '0;
         sec_d = '0;
         if (ENTM) begin
            if (updown) min_d = (min_q == 6'd0)  ? 6'd59 : min_q - 6'd1;
            else        min_d = (min_q == 6'd59) ? 6'd0  : min_q + 6'd1;
         end
         if (ENTH) begin
            if (updown) hr_d = (hr_q == 5'd0)  ? 5'd23 : hr_q - 5'd1;
            else        hr_d = (hr_q == 5'd23) ? 5'd0  : hr_q + 5'd1;
         end
      end else begin
         pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
         if (tick_int) begin
            if (sec_q == 6'd59) begin
               sec_d = '0;
               if (min_q == 6'd59) begin
                  min_d = '0;
                  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
      end
   end

   // Compare against the post-edge time so the ring starts with the matching second.
   always_comb match = tick_int && alarm_en && (hr_d == al_h_q) && (min_d == al_m_q) &&
                       (sec_d == 6'd0);
   always_comb ring_clr = alarm_stop || !alarm_en || adjust;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         sec_q  <= '0;
         min_q  <= '0;
         hr_q   <= '0;
         al_h_q <= '0;
         al_m_q <= '0;
         rcnt_q <= '0;
         ring_q <= RING_IDLE;
      end else begin
         pre_q <= pre_d;
         sec_q <= sec_d;
         min_q <= min_d;
         hr_q  <= hr_d;
         if (alarm_load && (alarm_h <= 5'd23) && (alarm_m <= 6'd59)) begin
            al_h_q <= alarm_h;
            al_m_q <= alarm_m;
         end
         if (ring_clr) begin
            ring_q <= RING_IDLE;
            rcnt_q <= '0;
         end else if (match) begin
            ring_q <= RING_ON;
            rcnt_q <= '0;
         end else if ((ring_q == RING_ON) && tick_int) begin
            if (rcnt_q == RMAX) begin
               ring_q <= RING_IDLE;
               rcnt_q <= '0;
            end else begin
               rcnt_q <= rcnt_q + 8'd1;
            end
         end
      end
   end

   function automatic logic [6:0] bcd60(input logic [5:0] v);
      logic [2:0] t;
      t = 3'd0;
      for (int unsigned i = 1; i < 6; i++)
         if (v >= 6'(10 * i)) t = 3'(i);
      return {t, 4'(v - 6'(t) * 6'd10)};
   endfunction

   always_comb begin
      disp_h = hr_q;
      if (MODE_12H != 0) begin
         if (hr_q == 5'd0)      disp_h = 5'd12;
         else if (hr_q > 5'd12) disp_h = hr_q - 5'd12;
      end
   end

   always_comb begin
      if (disp_h >= 5'd20) begin
         H1 = 2'd2;
         H2 = 4'(disp_h - 5'd20);
      end else if (disp_h >= 5'd10) begin
         H1 = 2'd1;
         H2 = 4'(disp_h - 5'd10);
      end else begin
         H1 = 2'd0;
         H2 = 4'(disp_h);
      end
   end

   assign {M1, M2}   = bcd60(min_q);
   assign {S1, S2}   = bcd60(sec_q);
   assign pm         = (MODE_12H != 0) && (hr_q >= 5'd12);
   assign tick       = tick_int;
   assign alarm_ring = (ring_q == RING_ON);

endmodule

// File: tb/tb_time_core_alarm.sv
// Bench for time_core_alarm: a fast 24 h instance (TICK_DIV=1, RING_SECS=3) and a
// 12 h instance (TICK_DIV=4) share stimulus; expectations go through a scoreboard queue.
module tb_time_core_alarm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       adjust = 1'b0, ENTH = 1'b0, ENTM = 1'b0, updown = 1'b0;
   logic [4:0] alarm_h = '0;
   logic [5:0] alarm_m = '0;
   logic       alarm_load = 1'b0, alarm_en = 1'b0, alarm_stop = 1'b0;

   logic [1:0] a_H1, b_H1;
   logic [3:0] a_H2, b_H2, a_M2, b_M2, a_S2, b_S2;
   logic [2:0] a_M1, b_M1, a_S1, b_S1;
   logic       a_pm, b_pm, a_tick, b_tick, a_ring, b_ring;

   time_core_alarm #(.TICK_DIV(1), .MODE_12H(0), .RING_SECS(3)) u_a (
      .clk(clk), .rst(rst), .adjust(adjust), .ENTH(ENTH), .ENTM(ENTM), .updown(updown),
      .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_load(alarm_load), .alarm_en(alarm_en),
      .alarm_stop(alarm_stop), .H1(a_H1), .H2(a_H2), .M1(a_M1), .M2(a_M2), .S1(a_S1),
      .S2(a_S2), .pm(a_pm), .tick(a_tick), .alarm_ring(a_ring));

   time_core_alarm #(.TICK_DIV(4), .MODE_12H(1), .RING_SECS(60)) u_b (
      .clk(clk), .rst(rst), .adjust(adjust), .ENTH(ENTH), .ENTM(ENTM), .updown(updown),
      .alarm_h(alarm_h), .alarm_m(alarm_m), .alarm_load(alarm_load), .alarm_en(alarm_en),
      .alarm_stop(alarm_stop), .H1(b_H1), .H2(b_H2), .M1(b_M1), .M2(b_M2), .S1(b_S1),
      .S2(b_S2), .pm(b_pm), .tick(b_tick), .alarm_ring(b_ring));

   always #5 clk = ~clk;

   localparam int SEL_A_HMS  = 0;
   localparam int SEL_A_TICK = 1;
   localparam int SEL_A_RING = 2;
   localparam int SEL_B_HMS  = 3;
   localparam int SEL_B_HP   = 4;
   localparam int SEL_B_TICK = 5;

   typedef struct {
      string       name;
      int          sel;
      logic [23:0] exp;
   } sb_t;

   typedef struct {
      logic        adj;
      logic        enth;
      logic        entm;
      logic        dn;
      logic [23:0] a_hms;
      logic [23:0] b_hp;
   } vec_t;

   sb_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   function automatic logic [23:0] obs(int sel);
      case (sel)
         SEL_A_HMS:  return {2'b00, a_H1, a_H2, 1'b0, a_M1, a_M2, 1'b0, a_S1, a_S2};
         SEL_A_TICK: return {23'd0, a_tick};
         SEL_A_RING: return {23'd0, a_ring};
         SEL_B_HMS:  return {2'b00, b_H1, b_H2, 1'b0, b_M1, b_M2, 1'b0, b_S1, b_S2};
         SEL_B_HP:   return {15'd0, b_pm, 2'b00, b_H1, b_H2};
         SEL_B_TICK: return {23'd0, b_tick};
         default:    return '1;
      endcase
   endfunction

   function automatic logic [7:0] bcd(int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic logic [23:0] hms(int h, int m, int s);
      return {bcd(h), bcd(m), bcd(s)};
   endfunction

   function automatic logic [23:0] hp12(int h);
      int d;
      d = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
      return {15'd0, (h >= 12) ? 1'b1 : 1'b0, bcd(d)};
   endfunction

   task automatic want(string n, int sel, logic [23:0] e);
      sb.push_back('{n, sel, e});
   endtask

   task automatic flush();
      sb_t         e;
      logic [23:0] a;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         a = obs(e.sel);
         n_tests++;
         if (a !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", e.name, a, e.exp, $time);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      flush();
   endtask

   task automatic drive(logic adj, logic enth, logic entm, logic dn);
      adjust = adj;
      ENTH   = enth;
      ENTM   = entm;
      updown = dn;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, hms(0, 0, 0),   hp12(0)};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, hms(0, 59, 0),  hp12(0)};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, hms(23, 59, 0), hp12(23)};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, hms(23, 0, 0),  hp12(23)};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, hms(23, 59, 0), hp12(23)};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, hms(0, 59, 0),  hp12(0)};
      tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, hms(1, 0, 0),   hp12(1)};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, hms(0, 59, 0),  hp12(0)};
      tbl[8] = '{1'b1, 1'b1, 0, 1'b1,    hms(23, 59, 0), hp12(23)};

      // asynchronous reset, no clock edge yet
      #1 rst = 1'b0;
      #1;
      want("rst_a_hms", SEL_A_HMS, hms(0, 0, 0));
      want("rst_a_tick", SEL_A_TICK, 24'd0);
      want("rst_a_ring", SEL_A_RING, 24'd0);
      want("rst_b_hms", SEL_B_HMS, hms(12, 0, 0));
      want("rst_b_hp", SEL_B_HP, hp12(0));
      want("rst_b_tick", SEL_B_TICK, 24'd0);
      flush();
      cycle();
      want("rst_hold_a_hms", SEL_A_HMS, hms(0, 0, 0));
      want("rst_hold_a_tick", SEL_A_TICK, 24'd0);
      flush();
      @(negedge clk);
      rst = 1'b1;

      // free run: A ticks every edge, B every 4th
      for (int k = 1; k <= 16; k++) begin
         want($sformatf("run_b_tick_%0d", k), SEL_B_TICK, 24'((k % 4) == 3));
         want($sformatf("run_a_secs_%0d", k), SEL_A_HMS, hms(0, 0, k));
         if (k == 16) want("run_b_4ticks", SEL_B_HMS, hms(12, 0, 4));
         cycle();
      end

      // adjust-mode vectors
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].adj, tbl[i].enth, tbl[i].entm, tbl[i].dn);
         want($sformatf("vec%0d_a_hms", i), SEL_A_HMS, tbl[i].a_hms);
         want($sformatf("vec%0d_b_hp", i), SEL_B_HP, tbl[i].b_hp);
         want($sformatf("vec%0d_a_tick", i), SEL_A_TICK, 24'(!tbl[i].adj));
         want($sformatf("vec%0d_b_tick", i), SEL_B_TICK, 24'd0);
         cycle();
      end

      // walk hours 23 -> 12 and back for the 12 h decode
      for (int i = 1; i <= 11; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1);
         want($sformatf("h12_dn_a_%0d", 23 - i), SEL_A_HMS, hms(23 - i, 59, 0));
         want($sformatf("h12_dn_b_%0d", 23 - i), SEL_B_HP, hp12(23 - i));
         cycle();
      end
      for (int i = 1; i <= 11; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0);
         want($sformatf("h12_up_a_%0d", 12 + i), SEL_A_HMS, hms(12 + i, 59, 0));
         cycle();
      end

      // steps ignored in run mode, then 23:59:00 + 60 ticks wraps the day
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      want("ignore_steps", SEL_A_HMS, hms(23, 59, 1));
      want("ignore_tick", SEL_A_TICK, 24'd1);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 2; k <= 59; k++) begin
         if (k == 59) want("pre_wrap", SEL_A_HMS, hms(23, 59, 59));
         cycle();
      end
      want("day_wrap", SEL_A_HMS, hms(0, 0, 0));
      want("day_wrap_tick", SEL_A_TICK, 24'd1);
      cycle();

      // alarm load (valid, then two out-of-range loads that must be ignored)
      adjust = 1'b1; alarm_en = 1'b1; alarm_load = 1'b1; alarm_h = 5'd0; alarm_m = 6'd1;
      want("al_adj_hms", SEL_A_HMS, hms(0, 0, 0));
      cycle();
      alarm_h = 5'd24; alarm_m = 6'd1;
      cycle();
      alarm_h = 5'd0; alarm_m = 6'd60;
      cycle();
      alarm_load = 1'b0; adjust = 1'b0;
      for (int k = 1; k <= 63; k++) begin
         want($sformatf("ring_auto_%0d", k), SEL_A_RING, 24'((k >= 60) && (k < 63)));
         if (k == 60) want("ring_auto_time", SEL_A_HMS, hms(0, 1, 0));
         cycle();
      end

      // second ring silenced by alarm_stop
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      want("al2_adj_hms", SEL_A_HMS, hms(0, 0, 0));
      want("al2_adj_ring", SEL_A_RING, 24'd0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 62; k++) begin
         if (k == 62) alarm_stop = 1'b1;
         want($sformatf("ring_stop_%0d", k), SEL_A_RING, 24'((k == 60) || (k == 61)));
         cycle();
      end
      alarm_stop = 1'b0;

      // third ring interrupted by an asynchronous reset
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      want("al3_adj_hms", SEL_A_HMS, hms(0, 0, 0));
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 60; k++) begin
         want($sformatf("ring3_%0d", k), SEL_A_RING, 24'(k == 60));
         cycle();
      end
      #3 rst = 1'b0;
      #1;
      want("arst_a_hms", SEL_A_HMS, hms(0, 0, 0));
      want("arst_a_ring", SEL_A_RING, 24'd0);
      want("arst_a_tick", SEL_A_TICK, 24'd0);
      want("arst_b_hms", SEL_B_HMS, hms(12, 0, 0));
      want("arst_b_hp", SEL_B_HP, hp12(0));
      flush();
      cycle();
      want("arst_hold_ring", SEL_A_RING, 24'd0);
      flush();

      // alarm registers must now hold 00:00
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      want("post_rst_set", SEL_A_HMS, hms(23, 59, 0));
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 60; k++) begin
         want($sformatf("ring_midnight_%0d", k), SEL_A_RING, 24'(k == 60));
         if (k == 60) want("midnight_time", SEL_A_HMS, hms(0, 0, 0));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_core_alarm.md
TIME_CORE_ALARM -- requirements
Module: time_core_alarm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second tick (legal >=1).
REQ-002 SHALL have parameter MODE_12H, default 0, display format (0 = 24 h, 1 = 12 h with pm flag).
REQ-003 SHALL have parameter RING_SECS, default 60, seconds the alarm rings before auto-stop (legal 1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port adjust  input  1  1 = time-set mode, 0 = run mode.
REQ-007 SHALL have ports ENTH, ENTM  input  1 each  per-cycle hour/minute step enables, adjust mode only.
REQ-008 SHALL have port updown  input  1  step direction (0 = up, 1 = down).
REQ-009 SHALL have ports alarm_h  input  5 and alarm_m  input  6  binary alarm hour/minute.
REQ-010 SHALL have ports alarm_load, alarm_en, alarm_stop  input  1 each  capture, arm, silence.
REQ-011 SHALL have outputs H1[1:0], H2[3:0], M1[2:0], M2[3:0], S1[2:0], S2[3:0]  BCD tens/units of hours, minutes, seconds.
REQ-012 SHALL have outputs pm  1  afternoon flag; tick  1  one-cycle second strobe; alarm_ring  1  alarm active.

Function
REQ-013 Prescaler SHALL count 0..TICK_DIV-1; tick=1 for exactly the cycle count==TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-014 While adjust=1 the prescaler SHALL be held at 0 and tick SHALL be 0.
REQ-015 Run mode: on tick, secs SHALL increment mod 60; mins SHALL increment mod 60 only when secs was 59; hours SHALL increment mod 24 only when mins:secs was 59:59.
REQ-016 Wrap 23:59:59 + tick SHALL yield 00:00:00 in the same edge.
REQ-017 Adjust mode: secs SHALL be 0 from the first edge with adjust=1 and held at 0 while adjust=1.
REQ-018 Adjust mode: each edge with ENTM=1 SHALL step mins by +1 (updown=0) or -1 (updown=1) mod 60, with no carry/borrow into hours.
REQ-019 Adjust mode: each edge with ENTH=1 SHALL step hours by +/-1 mod 24; ENTH and ENTM together SHALL step both.
REQ-020 ENTH, ENTM and updown SHALL be ignored while adjust=0.
REQ-021 Internal hours SHALL always be binary 0..23; secs/mins 0..59.
REQ-022 MODE_12H=0: H1/H2 SHALL be BCD of hours; pm SHALL be 0.
REQ-023 MODE_12H=1: displayed hour SHALL be 12 for hours 0 and 12, hours-12 for 13..23, hours otherwise; pm SHALL be 1 iff hours>=12.
REQ-024 Display outputs SHALL be combinational decode of registered counters (visible the cycle after the updating edge, no extra pipeline).
REQ-025 alarm_load=1 SHALL capture alarm_h/alarm_m into alarm registers if alarm_h<=23 and alarm_m<=59; otherwise the load SHALL be ignored.
REQ-026 alarm_ring SHALL set on a run-mode tick edge whose new time equals alarm_hh:alarm_mm:00 while alarm_en=1.
REQ-027 While ringing, an internal ring counter SHALL count ticks; alarm_ring SHALL clear on the edge the RING_SECS-th tick is taken.
REQ-028 alarm_ring SHALL clear on any edge with alarm_stop=1, alarm_en=0 or adjust=1; clear SHALL win over a same-edge set.
REQ-029 A new match while already ringing SHALL restart the ring counter.
REQ-030 Entering adjust mid-operation SHALL not alter hours or mins on that edge except via ENTH/ENTM.

Reset
REQ-031 rst=0 SHALL immediately clear prescaler, secs, mins, hours, alarm registers, ring counter, tick and alarm_ring regardless of clk.
REQ-032 During reset, time outputs SHALL read 00:00:00 (MODE_12H=1: hour display 12, pm=0).
REQ-033 After rst rises, the first tick SHALL occur TICK_DIV edges later.

Verification
REQ-034 TICK_DIV=4, run from reset -> tick every 4th cycle; after 4 ticks S2=4, S1=0.
REQ-035 Preset 23:59:58 via adjust then run, TICK_DIV=1 -> 00:00:00 after 2 ticks (adjust clears secs, so set 23:59 and run 60 ticks -> 00:00:00).
REQ-036 adjust=1, updown=1, ENTM pulse at mins=0 -> mins=59, hours unchanged; ENTH pulse at hours=0 -> hours=23.
REQ-037 MODE_12H=1 at hours 0, 12, 13 -> displays 12/pm=0, 12/pm=1, 01/pm=1.
REQ-038 alarm 00:01 loaded, alarm_en=1, TICK_DIV=1, RING_SECS=3 -> alarm_ring rises on tick 60, falls on 3rd tick after; repeat with alarm_stop mid-ring -> falls next edge.
REQ-039 rst pulsed low mid-count with alarm_ring=1 -> all outputs zero asynchronously, alarm registers 00:00.
